fp_series_feeder: RTL and testbench
===================================

# fp_series_feeder

Initiator side of the floating-point series-sum interface. The block collects N IEEE-754 single-precision words from an upstream valid/ready port and holds them in a local buffer. On a start command it clears the series adder, drives the buffered words onto the adder's `data` input one per cycle, waits the adder's output latency, then captures the adder's sum and presents it with a one-cycle valid strobe. It sits between the host/stimulus logic and `fp_series_add`, replacing hand-timed stimulus.

## Interface
- `N`, default 8: number of words per series; legal range ≥ 2.
- `LAT`, default 2: cycles from the last streamed word to a stable `adder_sum`; ≥ 1.
- `FTZ`, default 0: when 1, subnormal input words are flushed to signed zero on write.

- `clk`  in  1  the single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_data`  in  32  input float word.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  buffer can accept a word.
- `start`  in  1  request to run the series; honoured only in state FULL.
- `busy`  out  1  high in CLEAR, STREAM and WAIT.
- `adder_clear`  out  1  active-high reset to the adder.
- `adder_data`  out  32  word driven to the adder `data` input.
- `adder_sum`  in  32  adder `sum_out`.
- `sum`  out  32  captured series sum; holds until the next capture.
- `sum_valid`  out  1  one-cycle strobe when `sum` updates.

## Operation
- Buffer: N×32 register array; write index `wcnt` and read index `ridx`, each $clog2(N+1) bits wide.
- States: FILL, FULL, CLEAR, STREAM, WAIT.
  - FILL:
    - `in_ready`=1.
    - Handshake when `in_valid`&&`in_ready`: `buf[wcnt]`←word, then `wcnt`++.
    - Accepting word N-1 moves the FSM to FULL.
    - `start` is ignored.
  - FULL:
    - `in_ready`=0.
    - `start`=1 → CLEAR.
    - `in_valid` is ignored; the word is not consumed.
  - CLEAR: lasts one cycle. `adder_clear`=1, `ridx`←0, then → STREAM.
  - STREAM:
    - `adder_data`=`buf[ridx]`.
    - `ridx`++ each cycle.
    - After the cycle with `ridx`=N-1 → WAIT.
  - WAIT:
    - A counter runs LAT cycles.
    - On its last cycle the block captures `sum`←`adder_sum`.
    - `sum_valid` pulses in the following cycle, which is the first FILL cycle.
    - `wcnt`←0 and the FSM returns to FILL.
- Outputs are Moore-decoded from registered state.
- `adder_data` is 32'h0 outside STREAM.
- FTZ=1: a word with exponent 0 and mantissa ≠ 0 is stored as {sign, 31'b0}. All other words, including NaN and Inf, are stored unmodified. FTZ=0 stores every word verbatim.
- Simultaneous events:
  - The FILL→FULL transition and `start` in the same cycle: `start` is ignored; it must be re-asserted in FULL.
  - `start` held high across completion does not auto-restart, because the buffer is refilled first.
- Reset (asynchronous, any state, including mid-STREAM or mid-WAIT):
  - FSM→FILL; `wcnt`, `ridx` and the LAT counter→0.
  - `sum`←0, `sum_valid`=0, `adder_data`=0, `in_ready` becomes 1 after release.
  - `adder_clear` is forced to 1 combinationally while `reset` is low, so the adder is held in reset with the feeder.
  - Buffer contents are not reset and are don't-care.

## Timing
- Fill: one word per cycle at full throughput; N accepted words take N cycles.
- Command sequence, with c0 = the edge sampling `start`=1 in FULL:
  - Cycle after c0: CLEAR, `adder_clear`=1.
  - Next N cycles: STREAM, words 0..N-1 in order, one per cycle, with no gaps.
  - Next LAT cycles: WAIT.
  - Next cycle: `sum_valid`=1 and `sum` is updated.
- Command latency from `start` to `sum_valid` is N+LAT+2 cycles.
- `busy` is high for exactly N+LAT+1 cycles.
- `in_ready` rises in the same cycle as `sum_valid`.
- Back-to-back runs: minimum period is 2N+LAT+2 cycles.

## Test plan
- Reset check: `reset`=0 mid-STREAM at word 3 (N=8) → `adder_data`=0, `sum_valid`=0, `adder_clear`=1 immediately. After release: FILL, `in_ready`=1, `sum`=0.
- Basic run, N=8, LAT=2: fill eight words of 0x3F800000, pulse `start`. Then:
  - `adder_clear` is high exactly one cycle.
  - 0x3F800000 appears on `adder_data` for 8 consecutive cycles.
  - A reference adder model yields `sum`=0x41000000 with `sum_valid` exactly 12 cycles after the `start` edge.
- Ordering: fill 0x3F800000, 0x40000000, …, 0x41000000 (1.0..8.0) with random `in_valid` gaps → `adder_data` sequence is identical and gap-free; `sum`=0x42100000 (36.0).
- Backpressure: `in_valid` held high with a 9th word in FULL → `in_ready`=0 and the word is not consumed. `start` asserted during FILL is ignored: no `adder_clear`, `busy` stays 0.
- FTZ=1: write 0x80000001 and 0x00400000 → streamed as 0x80000000 and 0x00000000. 0x7FC00000 passes unchanged. With FTZ=0 all three pass unchanged.
- Back-to-back: two consecutive runs with different data and `start` held high throughout → exactly two `sum_valid` pulses, the second only after refill, and no restart without refill.

Source files
------------

// File: rtl/fp_series_feeder.sv
// Collects N single-precision words, streams them into fp_series_add after a
// one-cycle clear, then captures the adder's sum with a one-cycle valid strobe.
module fp_series_feeder #(
    parameter int N   = 8,
    parameter int LAT = 2,
    parameter int FTZ = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        start,
    output logic        busy,
    output logic        adder_clear,
    output logic [31:0] adder_data,
    input  logic [31:0] adder_sum,
    output logic [31:0] sum,
    output logic        sum_valid
);

    localparam int CW = $clog2(N + 1);
    localparam int IW = $clog2(N);
    localparam int LW = $clog2(LAT + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);
    localparam logic [LW-1:0] LAST_LAT = LW'(LAT - 1);

    typedef enum logic [2:0] {
        S_FILL   = 3'd0,
        S_FULL   = 3'd1,
        S_CLEAR  = 3'd2,
        S_STREAM = 3'd3,
        S_WAIT   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] wcnt_q, wcnt_d;
    logic [CW-1:0] ridx_q, ridx_d;
    logic [LW-1:0] lat_q, lat_d;
    logic [31:0]   sum_q, sum_d;
    logic          sum_valid_q, sum_valid_d;
    logic [31:0]   buf_q [N];
    logic          accept_s;

    // Subnormals become signed zero; NaN, Inf and normals pass untouched.
    function automatic logic [31:0] ftz_word(input logic [31:0] w);
        logic [31:0] r;
        if ((FTZ != 0) && (w[30:23] == 8'h00) && (w[22:0] != 23'h000000)) begin
            r = {w[31], 31'h0000_0000};
        end else begin
            r = w;
        end
        return r;
    endfunction

    assign accept_s = (state_q == S_FILL) && in_valid;

    // Next-state and datapath decisions for the feeder sequence.
    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        ridx_d      = ridx_q;
        lat_d       = lat_q;
        sum_d       = sum_q;
        sum_valid_d = 1'b0;
        case (state_q)
            S_FILL: begin
                if (accept_s) begin
                    wcnt_d = wcnt_q + CW'(1);
                    if (wcnt_q == LAST_IDX) begin
                        state_d = S_FULL;
                    end else begin
                        state_d = S_FILL;
                    end
                end else begin
                    wcnt_d = wcnt_q;
                end
            end
            S_FULL: begin
                if (start) begin
                    state_d = S_CLEAR;
                end else begin
                    state_d = S_FULL;
                end
            end
            S_CLEAR: begin
                ridx_d  = {CW{1'b0}};
                state_d = S_STREAM;
            end
            S_STREAM: begin
                ridx_d = ridx_q + CW'(1);
                if (ridx_q == LAST_IDX) begin
                    lat_d   = {LW{1'b0}};
                    state_d = S_WAIT;
                end else begin
                    state_d = S_STREAM;
                end
            end
            S_WAIT: begin
                if (lat_q == LAST_LAT) begin
                    sum_d       = adder_sum;
                    sum_valid_d = 1'b1;
                    wcnt_d      = {CW{1'b0}};
                    state_d     = S_FILL;
                end else begin
                    lat_d = lat_q + LW'(1);
                end
            end
            default: begin
                state_d = S_FILL;
            end
        endcase
    end

    // Control and result registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_FILL;
            wcnt_q      <= {CW{1'b0}};
            ridx_q      <= {CW{1'b0}};
            lat_q       <= {LW{1'b0}};
            sum_q       <= 32'h0000_0000;
            sum_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            ridx_q      <= ridx_d;
            lat_q       <= lat_d;
            sum_q       <= sum_d;
            sum_valid_q <= sum_valid_d;
        end
    end

    // Word buffer; contents are don't-care after reset, so it has none.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            buf_q[wcnt_q[IW-1:0]] <= ftz_word(in_data);
        end
    end

    assign in_ready    = (state_q == S_FILL);
    assign busy        = (state_q == S_CLEAR) || (state_q == S_STREAM) || (state_q == S_WAIT);
    // The adder is held in reset together with the feeder.
    assign adder_clear = (!reset) || (state_q == S_CLEAR);
    assign adder_data  = (state_q == S_STREAM) ? buf_q[ridx_q[IW-1:0]] : 32'h0000_0000;
    assign sum         = sum_q;
    assign sum_valid   = sum_valid_q;

endmodule

// File: tb/tb_fp_series_feeder.sv
// Directed/randomized bench for fp_series_feeder with a behavioural series adder
// model; instance a stores words verbatim, instance b flushes subnormals.
module tb_fp_series_feeder;

    localparam int N   = 8;
    localparam int LAT = 2;
    localparam int TOT = N + LAT + 2;

    logic        clk;
    logic        reset;
    logic [31:0] in_data;
    logic        in_valid;
    logic        start;
    logic        in_ready_a, busy_a, adder_clear_a, sum_valid_a;
    logic [31:0] adder_data_a, sum_a;
    logic        in_ready_b, busy_b, adder_clear_b, sum_valid_b;
    logic [31:0] adder_data_b, sum_b;
    logic [31:0] adder_sum_a;

    int          checks = 0;
    int          errors = 0;
    int          pulses = 0;
    logic [31:0] cur_w [N];

    real         acc;
    logic [31:0] pipe [LAT-1];

    fp_series_feeder #(.N(N), .LAT(LAT), .FTZ(0)) dut_a (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_a), .start(start), .busy(busy_a),
        .adder_clear(adder_clear_a), .adder_data(adder_data_a),
        .adder_sum(adder_sum_a), .sum(sum_a), .sum_valid(sum_valid_a)
    );

    fp_series_feeder #(.N(N), .LAT(LAT), .FTZ(1)) dut_b (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_b), .start(start), .busy(busy_b),
        .adder_clear(adder_clear_b), .adder_data(adder_data_b),
        .adder_sum(adder_sum_a), .sum(sum_b), .sum_valid(sum_valid_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic real f2r(input logic [31:0] w);
        logic [63:0] d;
        if (w[30:23] == 8'h00) return 0.0;
        d = {w[31], {3'b000, w[30:23]} + 11'd896, w[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] e;
        if (r == 0.0) return 32'h0000_0000;
        d = $realtobits(r);
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] ref_ftz(input logic [31:0] w);
        if (w[30:23] == 8'h00 && w[22:0] != 23'h000000) return {w[31], 31'h0000_0000};
        return w;
    endfunction

    function automatic logic [31:0] ref_sum();
        real s;
        s = 0.0;
        for (int i = 0; i < N; i++) s = s + f2r(cur_w[i]);
        return r2f(s);
    endfunction

    // Series adder model: accumulator plus LAT-1 output stages.
    always @(posedge clk) begin
        if (adder_clear_a) begin
            acc <= 0.0;
            for (int i = 0; i < LAT - 1; i++) pipe[i] <= 32'h0000_0000;
        end else begin
            acc <= acc + f2r(adder_data_a);
            pipe[0] <= r2f(acc);
            for (int i = 1; i < LAT - 1; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign adder_sum_a = pipe[LAT-2];

    // Counts sum_valid strobes of instance a.
    always @(posedge clk) begin
        if (sum_valid_a) pulses <= pulses + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input bit gaps);
        for (int i = 0; i < N; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b0;
                    tick();
                    chk("gap_ready", {31'd0, in_ready_a}, 32'd1);
                end
            end
            in_valid = 1'b1;
            in_data  = cur_w[i];
            chk("fill_ready_a", {31'd0, in_ready_a}, 32'd1);
            chk("fill_ready_b", {31'd0, in_ready_b}, 32'd1);
            chk("fill_busy", {31'd0, busy_a}, 32'd0);
            chk("fill_clear", {31'd0, adder_clear_a}, 32'd0);
            tick();
        end
        in_valid = 1'b0;
        chk("full_ready", {31'd0, in_ready_a}, 32'd0);
        chk("full_busy", {31'd0, busy_a | busy_b}, 32'd0);
    endtask

    // Issues start in FULL and checks every cycle up to the sum_valid strobe.
    task automatic run(input bit hold, input logic [31:0] exp_sum);
        logic [31:0] ed_a, ed_b;
        start = 1'b1;
        tick();
        if (!hold) start = 1'b0;
        for (int k = 1; k <= TOT; k++) begin
            ed_a = 32'h0000_0000;
            ed_b = 32'h0000_0000;
            if (k >= 2 && k <= N + 1) begin
                ed_a = cur_w[k-2];
                ed_b = ref_ftz(cur_w[k-2]);
            end
            chk("clear_a", {31'd0, adder_clear_a}, {31'd0, k == 1});
            chk("clear_b", {31'd0, adder_clear_b}, {31'd0, k == 1});
            chk("busy_a", {31'd0, busy_a}, {31'd0, k <= N + LAT + 1});
            chk("busy_b", {31'd0, busy_b}, {31'd0, k <= N + LAT + 1});
            chk("data_a", adder_data_a, ed_a);
            chk("data_b", adder_data_b, ed_b);
            chk("svalid_a", {31'd0, sum_valid_a}, {31'd0, k == TOT});
            chk("svalid_b", {31'd0, sum_valid_b}, {31'd0, k == TOT});
            if (k != TOT) tick();
        end
        chk("sum_a", sum_a, exp_sum);
        chk("sum_b", sum_b, exp_sum);
        chk("ready_at_valid", {31'd0, in_ready_a}, 32'd1);
        tick();
        chk("svalid_drop", {31'd0, sum_valid_a}, 32'd0);
        chk("sum_hold", sum_a, exp_sum);
    endtask

    initial begin
        int p0;
        logic [31:0] w;
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = 32'h0000_0000;
        start    = 1'b0;
        repeat (3) tick();
        chk("rst_clear", {31'd0, adder_clear_a}, 32'd1);
        chk("rst_data", adder_data_a, 32'h0000_0000);
        reset = 1'b1;
        tick();
        chk("post_rst_ready", {31'd0, in_ready_a}, 32'd1);
        chk("post_rst_sum", sum_a, 32'h0000_0000);
        chk("post_rst_svalid", {31'd0, sum_valid_a}, 32'd0);
        chk("post_rst_busy", {31'd0, busy_a}, 32'd0);
        chk("post_rst_clear", {31'd0, adder_clear_a}, 32'd0);

        // Basic: eight 1.0 words sum to 8.0.
        for (int i = 0; i < N; i++) cur_w[i] = 32'h3F80_0000;
        fill(1'b0);
        run(1'b0, 32'h4100_0000);

        // Ordering: 1.0..8.0 with random valid gaps sum to 36.0.
        for (int i = 0; i < N; i++) cur_w[i] = r2f(real'(i + 1));
        fill(1'b1);
        run(1'b0, 32'h4210_0000);

        // Reset asserted mid-stream while word 3 is on the adder input.
        for (int i = 0; i < N; i++) cur_w[i] = r2f(real'(10 * (i + 1)));
        fill(1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("pre_rst_word3", adder_data_a, cur_w[3]);
        reset = 1'b0;
        #1;
        chk("mid_rst_data", adder_data_a, 32'h0000_0000);
        chk("mid_rst_svalid", {31'd0, sum_valid_a}, 32'd0);
        chk("mid_rst_clear", {31'd0, adder_clear_a}, 32'd1);
        chk("mid_rst_busy", {31'd0, busy_a}, 32'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("rel_ready", {31'd0, in_ready_a}, 32'd1);
        chk("rel_sum", sum_a, 32'h0000_0000);
        chk("rel_clear", {31'd0, adder_clear_a}, 32'd0);
        chk("rel_busy", {31'd0, busy_a}, 32'd0);

        // Backpressure: a ninth word held valid in FULL is not consumed.
        for (int i = 0; i < N; i++) cur_w[i] = r2f(real'(3 * i + 2));
        fill(1'b0);
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        repeat (3) begin
            tick();
            chk("bp_ready", {31'd0, in_ready_a}, 32'd0);
            chk("bp_busy", {31'd0, busy_a}, 32'd0);
        end
        in_valid = 1'b0;
        run(1'b0, ref_sum());

        // Randomized series with random signs and gaps.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < N; i++) begin
                w = r2f(real'($urandom_range(1, 1000)));
                if ($urandom_range(0, 1) == 1) w[31] = 1'b1;
                cur_w[i] = w;
            end
            fill(1'b1);
            run(1'b0, ref_sum());
        end

        // Subnormal flush on instance b; NaN passes through on both.
        cur_w[0] = 32'h8000_0001;
        cur_w[1] = 32'h0040_0000;
        cur_w[2] = 32'h7FC0_0000;
        for (int i = 3; i < N; i++) cur_w[i] = 32'h3F80_0000;
        fill(1'b0);
        run(1'b0, ref_sum());

        // Back-to-back with start held high throughout.
        p0 = pulses;
        start = 1'b1;
        for (int i = 0; i < N; i++) cur_w[i] = r2f(real'(i + 5));
        fill(1'b1);
        run(1'b1, ref_sum());
        for (int i = 0; i < N; i++) cur_w[i] = r2f(real'(100 - 7 * i));
        fill(1'b0);
        run(1'b1, ref_sum());
        repeat (6) begin
            tick();
            chk("no_restart_busy", {31'd0, busy_a}, 32'd0);
            chk("no_restart_clear", {31'd0, adder_clear_a}, 32'd0);
            chk("no_restart_ready", {31'd0, in_ready_a}, 32'd1);
        end
        start = 1'b0;
        chk("b2b_pulses", pulses - p0, 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
